user_bp_dir_sequencer: RTL and testbench

//  Break-before-make sequencer between the backplane direction/output registers and the backplane pins.

---
 rtl/user_bp_dir_sequencer.sv | 106 ++++++++++
 tb/tb_user_bp_dir_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/user_bp_dir_sequencer.sv
// Break-before-make direction sequencer between the GPIO register bank and the backplane pads.
// Lines turning output->input release at once; input->output lines drive after a turnaround gap.
module user_bp_dir_sequencer #(
  parameter int unsigned NrBackplaneIos   = 32,
  parameter int unsigned TurnaroundCycles = 4,
  parameter int unsigned CntWidth         = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic [NrBackplaneIos-1:0] dir_req_i,
  input  logic [NrBackplaneIos-1:0] out_req_i,
  output logic [NrBackplaneIos-1:0] backplane_dir_o,
  output logic [NrBackplaneIos-1:0] backplane_out_o,
  output logic                      busy_o,
  output logic                      done_o
);

  typedef enum logic [1:0] {StIdle, StRelease, StWait, StDrive} state_e;

  localparam logic [CntWidth-1:0] CntInit = CntWidth'(TurnaroundCycles - 1);

  state_e                    state_q, state_d;
  logic [NrBackplaneIos-1:0] dir_q, dir_d;
  logic [NrBackplaneIos-1:0] out_q, out_d;
  logic [NrBackplaneIos-1:0] target_q, target_d;
  logic [CntWidth-1:0]       cnt_q, cnt_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;

    if (!enable_i) begin
      // Safe state: every line becomes an input; target/cnt are left as they are.
      state_d = StIdle;
      dir_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (dir_req_i != dir_q) begin
            target_d = dir_req_i;
            state_d  = StRelease;
          end
        end
        StRelease: begin
          dir_d = dir_q & target_q;
          if ((target_q & ~dir_q) == '0) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d   = CntInit;
            state_d = StWait;
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_d = StDrive;
          end else begin
            cnt_d = cnt_q - CntWidth'(1);
          end
        end
        StDrive: begin
          dir_d   = target_q;
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    // A line that is not driven always presents 0 on its output value.
    out_d  = out_req_i & dir_d;
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      dir_q    <= '0;
      out_q    <= '0;
      target_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      out_q    <= out_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign backplane_dir_o = dir_q;
  assign backplane_out_o = out_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

endmodule

// File: tb/tb_user_bp_dir_sequencer.sv
// Directed bench for user_bp_dir_sequencer (N=8, T=4): expected pad state per cycle is queued
// as stimulus is driven and compared once the DUT has taken the following clock edge.
module tb_user_bp_dir_sequencer;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [N-1:0] dir_req;
  logic [N-1:0] out_req;
  logic [N-1:0] backplane_dir;
  logic [N-1:0] backplane_out;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [N-1:0] dir;
    logic [N-1:0] out;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  user_bp_dir_sequencer #(
    .NrBackplaneIos  (N),
    .TurnaroundCycles(4),
    .CntWidth        (8)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .enable_i       (enable),
    .dir_req_i      (dir_req),
    .out_req_i      (out_req),
    .backplane_dir_o(backplane_dir),
    .backplane_out_o(backplane_out),
    .busy_o         (busy),
    .done_o         (done)
  );

  always #5 clk = ~clk;

  // Queue the expected result of the coming edge, take the edge, then pop and compare.
  task automatic cyc(input string tag, input logic [N-1:0] dir, input logic b, input logic d);
    exp_t e;
    e.dir  = dir;
    e.out  = out_req & dir;
    e.busy = b;
    e.done = d;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    tag = tag_q.pop_front();
    checks += 4;
    assert (backplane_dir === e.dir) else begin
      errors++;
      $error("FAIL %s dir: got %h expected %h", tag, backplane_dir, e.dir);
    end
    assert (backplane_out === e.out) else begin
      errors++;
      $error("FAIL %s out: got %h expected %h", tag, backplane_out, e.out);
    end
    assert (busy === e.busy) else begin
      errors++;
      $error("FAIL %s busy: got %b expected %b", tag, busy, e.busy);
    end
    assert (done === e.done) else begin
      errors++;
      $error("FAIL %s done: got %b expected %b", tag, done, e.done);
    end
  endtask

  initial begin
    rst     = 1'b1;
    enable  = 1'b1;
    dir_req = 8'h00;
    out_req = 8'hA5;
    @(posedge clk);
    #1;
    cyc("reset", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;

    // 1. Quiet idle: no change, no done.
    repeat (3) cyc("idle", 8'h00, 1'b0, 1'b0);

    // 2. Rising-only 0x00 -> 0x0F: full turnaround.
    dir_req = 8'h0F;
    cyc("rise_e0", 8'h00, 1'b1, 1'b0);
    repeat (5) cyc("rise_gap", 8'h00, 1'b1, 1'b0);
    cyc("rise_drive", 8'h0F, 1'b0, 1'b1);
    cyc("rise_after", 8'h0F, 1'b0, 1'b0);
    out_req = 8'h3C;
    cyc("rise_out", 8'h0F, 1'b0, 1'b0);

    // Reach 0xF0: falls clear at E1, rises after the gap.
    dir_req = 8'hF0;
    cyc("swap_e0", 8'h0F, 1'b1, 1'b0);
    repeat (5) cyc("swap_gap", 8'h00, 1'b1, 1'b0);
    cyc("swap_drive", 8'hF0, 1'b0, 1'b1);

    // 3. Falling-only 0xF0 -> 0x30: done at E1, busy one cycle.
    dir_req = 8'h30;
    cyc("fall_e0", 8'hF0, 1'b1, 1'b0);
    cyc("fall_e1", 8'h30, 1'b0, 1'b1);
    cyc("fall_after", 8'h30, 1'b0, 1'b0);

    // Back to 0xF0, then 4. 0xF0 -> 0x0F with break-before-make.
    dir_req = 8'hF0;
    cyc("back_e0", 8'h30, 1'b1, 1'b0);
    repeat (5) cyc("back_gap", 8'h30, 1'b1, 1'b0);
    cyc("back_drive", 8'hF0, 1'b0, 1'b1);
    dir_req = 8'h0F;
    cyc("bbm_e0", 8'hF0, 1'b1, 1'b0);
    repeat (5) cyc("bbm_gap", 8'h00, 1'b1, 1'b0);
    cyc("bbm_drive", 8'h0F, 1'b0, 1'b1);
    cyc("bbm_after", 8'h0F, 1'b0, 1'b0);

    // 5. Request changed during WAIT is held off until IDLE, then sequenced in full.
    dir_req = 8'h00;
    cyc("clr_e0", 8'h0F, 1'b1, 1'b0);
    cyc("clr_e1", 8'h00, 1'b0, 1'b1);
    dir_req = 8'h0F;
    cyc("late_e0", 8'h00, 1'b1, 1'b0);
    cyc("late_e1", 8'h00, 1'b1, 1'b0);
    dir_req = 8'hFF;
    repeat (4) cyc("late_gap", 8'h00, 1'b1, 1'b0);
    cyc("late_first", 8'h0F, 1'b0, 1'b1);
    cyc("late_reeval", 8'h0F, 1'b1, 1'b0);
    repeat (5) cyc("late_gap2", 8'h0F, 1'b1, 1'b0);
    cyc("late_second", 8'hFF, 1'b0, 1'b1);
    cyc("late_after", 8'hFF, 1'b0, 1'b0);

    // 6a. enable pulsed low mid-WAIT, then full re-sequence from all-input.
    dir_req = 8'h0F;
    cyc("en_prep_e0", 8'hFF, 1'b1, 1'b0);
    cyc("en_prep_e1", 8'h0F, 1'b0, 1'b1);
    dir_req = 8'hFF;
    cyc("en_e0", 8'h0F, 1'b1, 1'b0);
    cyc("en_e1", 8'h0F, 1'b1, 1'b0);
    cyc("en_wait", 8'h0F, 1'b1, 1'b0);
    enable = 1'b0;
    cyc("en_off", 8'h00, 1'b0, 1'b0);
    enable = 1'b1;
    cyc("en_on_e0", 8'h00, 1'b1, 1'b0);
    repeat (5) cyc("en_on_gap", 8'h00, 1'b1, 1'b0);
    cyc("en_on_drive", 8'hFF, 1'b0, 1'b1);

    // 6b. rst asserted mid-WAIT, then full re-sequence.
    dir_req = 8'h0F;
    cyc("rst_prep_e0", 8'hFF, 1'b1, 1'b0);
    cyc("rst_prep_e1", 8'h0F, 1'b0, 1'b1);
    dir_req = 8'hFF;
    cyc("rst_e0", 8'h0F, 1'b1, 1'b0);
    cyc("rst_e1", 8'h0F, 1'b1, 1'b0);
    cyc("rst_wait", 8'h0F, 1'b1, 1'b0);
    rst = 1'b1;
    cyc("rst_on", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    cyc("rst_off_e0", 8'h00, 1'b1, 1'b0);
    repeat (5) cyc("rst_off_gap", 8'h00, 1'b1, 1'b0);
    cyc("rst_off_drive", 8'hFF, 1'b0, 1'b1);
    cyc("rst_off_after", 8'hFF, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
